// File: rtl/round_controller.sv
// Match sequencer for the two-tank game: start-key detection, spawn pulses with seeds,
// score keeping, respawn countdown and winner declaration.
module round_controller #(
  parameter int unsigned RESPAWN_FRAMES = 60,
  parameter int unsigned WIN_SCORE      = 5,
  parameter logic [7:0]  START_KEY      = 8'h28
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycode,
  input  logic        TankDead_1,
  input  logic        TankDead_2,
  output logic        relife,
  output logic [1:0]  random_seed_1,
  output logic [1:0]  random_seed_2,
  output logic [3:0]  score_1,
  output logic [3:0]  score_2,
  output logic [1:0]  winner,
  output logic        freeze,
  output logic [2:0]  game_state,
  output logic [7:0]  countdown
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSpawn   = 3'd1,
    StPlay    = 3'd2,
    StRespawn = 3'd3,
    StOver    = 3'd4
  } state_e;

  localparam logic [3:0] WinScore    = 4'(WIN_SCORE);
  localparam logic [7:0] RespawnLoad = 8'(RESPAWN_FRAMES - 1);
  localparam logic [7:0] LfsrSeed    = 8'hA5;

  state_e      state_q, state_d;
  logic        key_seen_q;
  logic        guard_q;
  logic        relife_q;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [1:0]  seed_q, seed_d;
  logic [3:0]  score1_q, score1_d;
  logic [3:0]  score2_q, score2_d;
  logic [1:0]  winner_q, winner_d;
  logic [7:0]  count_q, count_d;

  logic key_present, start_evt;
  logic sample, p1_point, p2_point, draw, p1_wins, p2_wins;

  always_comb begin
    key_present = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (keycode[8*i +: 8] == START_KEY) key_present = 1'b1;
    end
  end

  assign start_evt = key_present & ~key_seen_q;

  // The first PLAY cycle is a guard while the tanks clear their dead flags.
  assign sample   = (state_q == StPlay) && !guard_q;
  assign p1_point = sample && TankDead_2 && !TankDead_1;
  assign p2_point = sample && TankDead_1 && !TankDead_2;
  assign draw     = sample && TankDead_1 && TankDead_2;
  assign p1_wins  = p1_point && (score1_q + 4'd1 == WinScore);
  assign p2_wins  = p2_point && (score2_q + 4'd1 == WinScore);

  // State register.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StOver: if (start_evt) state_d = StSpawn;
      StSpawn:        state_d = StPlay;
      StPlay: begin
        if (p1_wins || p2_wins) state_d = StOver;
        else if (p1_point || p2_point || draw) state_d = StRespawn;
      end
      StRespawn:      if (count_q == 8'd0) state_d = StSpawn;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    if ((state_q == StIdle || state_q == StOver) && start_evt) begin
      score1_d = 4'd0;
      score2_d = 4'd0;
      winner_d = 2'b00;
    end else begin
      if (p1_point && score1_q < WinScore) score1_d = score1_q + 4'd1;
      if (p2_point && score2_q < WinScore) score2_d = score2_q + 4'd1;
      if (p1_wins) winner_d = 2'b01;
      if (p2_wins) winner_d = 2'b10;
    end

    count_d = 8'd0;
    if (state_d == StRespawn) begin
      count_d = (state_q == StRespawn) ? count_q - 8'd1 : RespawnLoad;
    end

    seed_d = seed_q;
    if (state_d == StSpawn && state_q != StSpawn) seed_d = lfsr_q[1:0];

    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    // Lock-up recovery; the register should never hold zero.
    if (lfsr_q == 8'd0) lfsr_d = LfsrSeed;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      key_seen_q <= 1'b0;
      guard_q    <= 1'b0;
      relife_q   <= 1'b0;
      lfsr_q     <= LfsrSeed;
      seed_q     <= 2'b00;
      score1_q   <= 4'd0;
      score2_q   <= 4'd0;
      winner_q   <= 2'b00;
      count_q    <= 8'd0;
    end else begin
      key_seen_q <= key_present;
      guard_q    <= (state_q == StSpawn);
      relife_q   <= (state_d == StSpawn);
      lfsr_q     <= lfsr_d;
      seed_q     <= seed_d;
      score1_q   <= score1_d;
      score2_q   <= score2_d;
      winner_q   <= winner_d;
      count_q    <= count_d;
    end
  end

  // Outputs, all taken from registered state.
  always_comb begin
    game_state    = state_q;
    freeze        = (state_q != StPlay);
    relife        = relife_q;
    random_seed_1 = seed_q;
    random_seed_2 = seed_q ^ 2'b11;
    score_1       = score1_q;
    score_2       = score2_q;
    winner        = winner_q;
    countdown     = count_q;
  end

endmodule

// File: doc/round_controller.md
# round_controller

Sequences a two-tank match around the two `tank` instances. It waits for a start key, then pulses `relife` to respawn both tanks with fresh random spawn seeds. It watches `TankDead` from each tank, keeps score, and holds a respawn countdown between rounds. When a player reaches the winning score it declares a winner and freezes play until the start key is pressed again.

## Interface
Parameters:
- RESPAWN_FRAMES, 60: length of the respawn pause in frame_clk cycles; legal range 1..255.
- WIN_SCORE, 5: score that ends the match; legal range 1..15.
- START_KEY, 8'h28: HID keycode that starts or restarts a match (Enter).

Ports:
- frame_clk  in  1  sole clock, one edge per video frame.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- keycode  in  32  four HID keycode bytes; START_KEY may appear in any byte.
- TankDead_1  in  1  dead flag from tank 1; held until that tank is relifed.
- TankDead_2  in  1  dead flag from tank 2; held until that tank is relifed.
- relife  out  1  respawn pulse to both tanks; one cycle wide, registered.
- random_seed_1  out  2  spawn seed for tank 1; stable while relife is high.
- random_seed_2  out  2  spawn seed for tank 2; always random_seed_1 ^ 2'b11.
- score_1  out  4  rounds won by player 1.
- score_2  out  4  rounds won by player 2.
- winner  out  2  00 none, 01 player 1, 10 player 2.
- freeze  out  1  1 in every state except PLAY; used to gate keycodes and shooting.
- game_state  out  3  current FSM state, encoded as listed under Operation.
- countdown  out  8  frames remaining in RESPAWN; 0 in all other states.

## Operation
- FSM states and encodings: IDLE=0, SPAWN=1, PLAY=2, RESPAWN=3, OVER=4.
- Start event: START_KEY present in any keycode byte this cycle and absent in the previous cycle. Detection uses a registered presence flag, so a held key does not repeat.
- IDLE -> SPAWN on a start event. score_1, score_2 and winner clear on that same edge.
- SPAWN lasts exactly 1 cycle:
  - relife = 1 throughout the cycle.
  - Seeds are captured on the edge entering SPAWN: random_seed_1 <= lfsr[1:0].
  - SPAWN -> PLAY unconditionally.
- PLAY: the dead flags are ignored in the first PLAY cycle, which is a guard cycle while the tanks clear. From the second cycle onward, on each edge:
  - Only TankDead_1 high: score_2 +1.
  - Only TankDead_2 high: score_1 +1.
  - Both high in the same cycle: draw, no score change, go to RESPAWN.
  - After any score change: if the new score equals WIN_SCORE, go to OVER and set winner to that player; otherwise go to RESPAWN.
- RESPAWN:
  - countdown loads RESPAWN_FRAMES-1 on entry and decrements by 1 each cycle.
  - On the edge where countdown==0, go to SPAWN.
  - Dead flags and keycode are ignored.
- OVER: winner and scores hold. A start event clears the scores and winner and goes to SPAWN.
- Scores never wrap; they saturate at WIN_SCORE.
- LFSR:
  - 8 bits, reset value 8'hA5.
  - Free-runs every cycle in all states: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - It must never reach all-zero.

## Timing
- Reset values: game_state=IDLE, relife=0, random_seed_1=2'b00, random_seed_2=2'b11, score_1=score_2=0, winner=00, freeze=1, countdown=0, lfsr=8'hA5, start-presence flag=0.
- All outputs are registered. freeze is decoded from the registered state and has no combinational path from the inputs.
- Start event in cycle N: game_state=SPAWN and relife=1 in cycle N+1; PLAY in N+2; dead flags are sampled from N+3.
- Death sampled at edge E: the score update and the state change are both visible after edge E.
- RESPAWN occupies exactly RESPAWN_FRAMES cycles, then one SPAWN cycle.
- Reset asserted mid-operation, including during a relife pulse, forces the reset values asynchronously. relife drops immediately.

## Test plan
- Reset, then hold keycode=32'h00000028 for 5 cycles:
  - Exactly one relife pulse, in cycle N+1.
  - random_seed_1=lfsr[1:0] of the capture edge; random_seed_2 is its complement.
  - game_state goes 1 then 2; no second start.
- In PLAY, raise TankDead_2 from the third PLAY cycle:
  - score_1=1 and game_state=3 on the next edge.
  - countdown reads 59..0 over 60 cycles, then one relife pulse, then PLAY.
- In PLAY, raise TankDead_1 and TankDead_2 in the same cycle -> scores unchanged, game_state=3.
- Run until score_1=4, then raise TankDead_2 in PLAY -> score_1=5, winner=01, game_state=4, freeze=1. Further dead pulses do not change the scores.
- In OVER with START_KEY held from entry -> no restart. Release, then press again in keycode[31:24] -> scores=0, winner=00, SPAWN.
- Assert Reset during the SPAWN cycle -> relife falls immediately and all outputs return to their reset values without waiting for a clock edge.
